// File: rtl/mm_stream_if.sv
// mm_stream_if: bundles the input stream, output stream, BRAM port and
// multiplier handshake of the matrix-multiply front-end controller.
// master = controller side, slave = environment (source, sink, BRAM, core).
interface mm_stream_if #(
   parameter int L_RAM_SIZE = 3,
   parameter int BITWIDTH   = 32
);
   logic [BITWIDTH-1:0]     s_tdata;
   logic                    s_tvalid;
   logic                    s_tready;
   logic                    s_tlast;
   logic [BITWIDTH-1:0]     m_tdata;
   logic                    m_tvalid;
   logic                    m_tready;
   logic                    m_tlast;
   logic [2*L_RAM_SIZE:0]   bram_addr;
   logic [BITWIDTH-1:0]     bram_wrdata;
   logic                    bram_we;
   logic [BITWIDTH-1:0]     bram_rddata;
   logic                    bram_sel;
   logic                    mm_start;
   logic                    mm_done;
   logic                    err;

   modport master (
      input  s_tdata, s_tvalid, s_tlast,
      output s_tready,
      output m_tdata, m_tvalid, m_tlast,
      input  m_tready,
      output bram_addr, bram_wrdata, bram_we, bram_sel,
      input  bram_rddata,
      output mm_start,
      input  mm_done,
      output err
   );

   modport slave (
      output s_tdata, s_tvalid, s_tlast,
      input  s_tready,
      input  m_tdata, m_tvalid, m_tlast,
      output m_tready,
      input  bram_addr, bram_wrdata, bram_we, bram_sel,
      output bram_rddata,
      input  mm_start,
      output mm_done,
      input  err
   );
endinterface

// File: rtl/mm_stream_ctrl.sv
// mm_stream_ctrl: front-end for the shared matrix BRAM. Loads A then B
// (2*N^2 words) from the input stream, kicks the multiplier, waits for done,
// then streams the N^2 results out through a 2-entry FIFO with backpressure.
// Optional macro MM_TLAST_CHECK_EN enables the sticky s_tlast framing check;
// without it s_tlast is ignored and err is tied low.
module mm_stream_ctrl #(
   parameter int L_RAM_SIZE = 3,
   parameter int BITWIDTH   = 32
) (
   input  logic         clk,
   input  logic         reset,
   mm_stream_if.master  bus
);
   localparam int AW = 2*L_RAM_SIZE + 1;
   localparam int N2 = 1 << (2*L_RAM_SIZE);
   localparam logic [AW-1:0] FILL_LAST = AW'(2*N2 - 1);
   localparam logic [AW-1:0] RD_END    = AW'(N2);
   localparam logic [AW-1:0] OUT_LAST  = AW'(N2 - 1);

   typedef enum logic [1:0] {S_FILL, S_KICK, S_WAIT, S_DRAIN} state_t;

   state_t              state, state_next;
   logic [AW-1:0]       fill_cnt, rd_cnt, out_cnt;
   logic                s_tready_r;
   logic [BITWIDTH-1:0] fifo_mem [2];
   logic                wr_ptr, rd_ptr;
   logic [1:0]          fifo_count;
   logic                inflight_p1;
   logic [2:0]          occupancy;
   logic                accept, pop, issue, fill_done, drain_done;
   logic                m_tvalid_c, sel_c, start_c;

   // Handshakes and read-issue decision. occupancy counts words already in
   // the FIFO or on their way from BRAM, net of the word leaving this cycle.
   assign accept     = (state == S_FILL) && s_tready_r && bus.s_tvalid;
   assign m_tvalid_c = (fifo_count != 2'd0);
   assign pop        = m_tvalid_c && bus.m_tready;
   assign occupancy  = {1'b0, fifo_count} + {2'b0, inflight_p1} - {2'b0, pop};
   assign issue      = (state == S_DRAIN) && (rd_cnt < RD_END) && (occupancy < 3'd2);
   assign fill_done  = accept && (fill_cnt == FILL_LAST);
   assign drain_done = pop && (out_cnt == OUT_LAST);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FILL;
      else       state <= state_next;
   end

   // Next-state logic, BRAM ownership and the start pulse
   always_comb begin
      state_next = state;
      sel_c      = 1'b1;
      start_c    = 1'b0;
      case (state)
         S_FILL:  if (fill_done) state_next = S_KICK;
         S_KICK: begin
            sel_c = 1'b0;
            // a done left over from the previous run must drop before we kick
            if (!bus.mm_done) begin
               start_c    = 1'b1;
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            sel_c = 1'b0;
            if (bus.mm_done) state_next = S_DRAIN;
         end
         S_DRAIN: if (drain_done) state_next = S_FILL;
         default: state_next = S_FILL;
      endcase
   end

   // Counters, registered s_tready and the one-cycle BRAM read tracker
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_cnt    <= '0;
         rd_cnt      <= '0;
         out_cnt     <= '0;
         s_tready_r  <= 1'b0;
         inflight_p1 <= 1'b0;
      end else begin
         s_tready_r  <= (state_next == S_FILL);
         inflight_p1 <= issue;
         if (accept) fill_cnt <= fill_cnt + 1'b1;
         if (issue)  rd_cnt   <= rd_cnt + 1'b1;
         if (pop)    out_cnt  <= out_cnt + 1'b1;
         if (drain_done) begin
            fill_cnt <= '0;
            rd_cnt   <= '0;
            out_cnt  <= '0;
         end
      end
   end

   // FIFO pointers and occupancy; push is the BRAM word issued last cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= 2'd0;
      end else begin
         if (inflight_p1) wr_ptr <= ~wr_ptr;
         if (pop)         rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + {1'b0, inflight_p1} - {1'b0, pop};
      end
   end

   // FIFO storage captures BRAM read data on return
   always_ff @(posedge clk) begin
      if (inflight_p1) fifo_mem[wr_ptr] <= bus.bram_rddata;
   end

   assign bus.s_tready    = s_tready_r;
   assign bus.m_tvalid    = m_tvalid_c;
   assign bus.m_tdata     = m_tvalid_c ? fifo_mem[rd_ptr] : '0;
   assign bus.m_tlast     = m_tvalid_c && (out_cnt == OUT_LAST);
   assign bus.bram_we     = accept;
   assign bus.bram_addr   = (state == S_DRAIN) ? rd_cnt : fill_cnt;
   assign bus.bram_wrdata = accept ? bus.s_tdata : '0;
   assign bus.bram_sel    = sel_c;
   assign bus.mm_start    = start_c;

`ifdef MM_TLAST_CHECK_EN
   logic err_r;

   // Sticky framing error: tlast must be high exactly on the final input beat
   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_r <= 1'b0;
      else if (accept && (bus.s_tlast != (fill_cnt == FILL_LAST))) err_r <= 1'b1;
   end

   assign bus.err = err_r;
`else
   logic unused_tlast;
   assign unused_tlast = bus.s_tlast;
   assign bus.err      = 1'b0;
`endif
endmodule

// File: tb/tb_mm_stream_ctrl.sv
// tb_mm_stream_ctrl: directed bench for mm_stream_ctrl with a BRAM model and
// a multiplier stub (done 20 cycles after start, held 5 cycles, results
// i+1000 at addresses 0..63).
module tb_mm_stream_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mm_stream_if #(.L_RAM_SIZE(3), .BITWIDTH(32)) bus ();

   mm_stream_ctrl #(.L_RAM_SIZE(3), .BITWIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] mem [0:127];

   // BRAM read port, one cycle latency
   always @(posedge clk) bus.bram_rddata <= mem[bus.bram_addr];

   // per-pass observations
   logic [31:0] got [0:63];
   int got_n, start_pulses, fill_errs, sel_errs, stall_errs, snap_errs;
   int last_cnt, last_idx, first_out, last_out, kick_cyc, start_cyc, done_first;
   int err_rise, tlast_cyc;

   task automatic idle_inputs();
      bus.s_tvalid = 1'b0;
      bus.s_tdata  = '0;
      bus.s_tlast  = 1'b0;
      bus.m_tready = 1'b0;
      bus.mm_done  = 1'b0;
   endtask

   // Drives one full load/compute/drain pass and records what the DUT did.
   task automatic run_pass(input int gap_mode, input int bp_mode, input int tlast_beat,
                           input int force_done, input int reset_after, output int ok);
      int feed, force_left;
      bit kickwait, started, prev_stall, in_fill, aborted;
      logic [31:0] prev_data;
      logic prev_last;
      got_n = 0; start_pulses = 0; fill_errs = 0; sel_errs = 0; stall_errs = 0;
      snap_errs = 0; last_cnt = 0; last_idx = -1; first_out = -1; last_out = -1;
      kick_cyc = -1; start_cyc = -1; done_first = -1; err_rise = -1; tlast_cyc = -1;
      for (int i = 0; i < 64; i++) got[i] = '0;
      feed = 0; force_left = 0; kickwait = 0; started = 0; prev_stall = 0;
      prev_data = '0; prev_last = 1'b0; ok = 0; aborted = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         in_fill = (feed < 128);
         if (in_fill) begin
            bus.s_tvalid = (gap_mode != 0) ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            bus.s_tdata  = 32'(feed + 1);
            bus.s_tlast  = (feed == tlast_beat);
         end else begin
            bus.s_tvalid = (gap_mode != 0);
            bus.s_tdata  = 32'hDEAD_BEEF;
            bus.s_tlast  = 1'b0;
         end
         bus.m_tready = (bp_mode != 0) ? ((cyc % 5) != 1 && (cyc % 5) != 4) : 1'b1;
         if (started && cyc == start_cyc + 20)
            for (int i = 0; i < 64; i++) mem[i] = 32'(1000 + i);
         bus.mm_done = (started && cyc >= start_cyc + 20 && cyc < start_cyc + 25) || (force_left > 0);
         if (force_left > 0) force_left--;
         #1;
         if (bus.bram_sel !== !kickwait) sel_errs++;
         if (kickwait && started && bus.mm_done === 1'b1) begin
            kickwait = 0;
            done_first = cyc;
         end
         if (bus.mm_start === 1'b1) begin
            start_pulses++;
            if (!started) begin
               started = 1;
               start_cyc = cyc;
               for (int i = 0; i < 128; i++) if (mem[i] !== 32'(i + 1)) snap_errs++;
            end
         end
         if (in_fill) begin
            if (bus.s_tready !== 1'b1 || bus.bram_we !== bus.s_tvalid) fill_errs++;
            if (bus.s_tvalid) begin
               if (bus.bram_addr !== 7'(feed) || bus.bram_wrdata !== 32'(feed + 1)) fill_errs++;
               if (feed == tlast_beat) tlast_cyc = cyc;
               feed++;
               if (feed == 128) begin
                  kickwait = 1;
                  kick_cyc = cyc + 1;
                  if (force_done != 0) force_left = 3;
               end
            end
         end else if (bus.s_tready !== 1'b0 || bus.bram_we !== 1'b0) fill_errs++;
         if (bus.bram_sel === 1'b1 && bus.bram_we === 1'b1) mem[bus.bram_addr] = bus.bram_wrdata;
         if (prev_stall && (bus.m_tvalid !== 1'b1 || bus.m_tdata !== prev_data || bus.m_tlast !== prev_last))
            stall_errs++;
         if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
            got[got_n] = bus.m_tdata;
            if (bus.m_tlast === 1'b1) begin last_cnt++; last_idx = got_n; end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            got_n++;
         end
         prev_stall = (bus.m_tvalid === 1'b1) && (bus.m_tready !== 1'b1);
         prev_data  = bus.m_tdata;
         prev_last  = bus.m_tlast;
         if (bus.err === 1'b1 && err_rise < 0) err_rise = cyc;
         if (reset_after > 0 && got_n == reset_after) begin
            @(negedge clk);
            idle_inputs();
            reset = 1'b1;
            #1;
            ok = 1;
            aborted = 1;
            break;
         end
         if (got_n == 64) begin
            @(posedge clk);
            ok = 1;
            break;
         end
      end
      if (!aborted) begin
         @(negedge clk);
         idle_inputs();
         #1;
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.s_tready, bus.m_tvalid, bus.m_tlast, bus.bram_we, bus.bram_sel, bus.mm_start, bus.err} !== 7'b0000100) begin
         failures++;
         $display("FAIL reset_ctrl got %b expected 0000100", {bus.s_tready, bus.m_tvalid, bus.m_tlast, bus.bram_we, bus.bram_sel, bus.mm_start, bus.err});
      end
      checks++;
      if (bus.m_tdata !== 32'd0 || bus.bram_addr !== 7'd0 || bus.bram_wrdata !== 32'd0) begin
         failures++;
         $display("FAIL reset_data got tdata=%h addr=%h wrdata=%h expected all zero", bus.m_tdata, bus.bram_addr, bus.bram_wrdata);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.s_tready !== 1'b1 || bus.bram_sel !== 1'b1) begin
         failures++;
         $display("FAIL reset_release got s_tready=%b bram_sel=%b expected 1 1", bus.s_tready, bus.bram_sel);
      end
   endtask

   task automatic test_basic();
      int ok;
      run_pass(0, 0, 127, 0, 0, ok);
      checks++; if (ok !== 1) begin failures++; $display("FAIL basic_complete got %0d expected 1", ok); end
      checks++; if (fill_errs !== 0) begin failures++; $display("FAIL basic_fill_writes got %0d errors expected 0", fill_errs); end
      checks++; if (snap_errs !== 0) begin failures++; $display("FAIL basic_bram_image got %0d bad words expected 0", snap_errs); end
      checks++; if (start_pulses !== 1) begin failures++; $display("FAIL basic_start_pulses got %0d expected 1", start_pulses); end
      checks++; if (start_cyc !== kick_cyc) begin failures++; $display("FAIL basic_start_cycle got %0d expected %0d", start_cyc, kick_cyc); end
      checks++; if (sel_errs !== 0) begin failures++; $display("FAIL basic_bram_sel got %0d bad cycles expected 0", sel_errs); end
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (got[i] !== 32'(1000 + i)) begin failures++; $display("FAIL basic_data[%0d] got %0d expected %0d", i, got[i], 1000 + i); end
      end
      checks++; if (last_cnt !== 1 || last_idx !== 63) begin failures++; $display("FAIL basic_tlast got count=%0d idx=%0d expected 1 63", last_cnt, last_idx); end
      checks++; if (first_out - done_first !== 3) begin failures++; $display("FAIL basic_latency got %0d expected 3", first_out - done_first); end
      checks++; if (last_out - first_out !== 63) begin failures++; $display("FAIL basic_throughput got span %0d expected 63", last_out - first_out); end
      checks++; if (err_rise !== -1) begin failures++; $display("FAIL basic_err got rise at %0d expected none", err_rise); end
      checks++; if (bus.s_tready !== 1'b1) begin failures++; $display("FAIL basic_refill_ready got %b expected 1", bus.s_tready); end
   endtask

   task automatic test_input_gaps();
      int ok, bad;
      run_pass(1, 0, 127, 0, 0, ok);
      checks++; if (ok !== 1) begin failures++; $display("FAIL gaps_complete got %0d expected 1", ok); end
      checks++; if (fill_errs !== 0) begin failures++; $display("FAIL gaps_writes got %0d errors expected 0", fill_errs); end
      checks++; if (snap_errs !== 0) begin failures++; $display("FAIL gaps_bram_image got %0d bad words expected 0", snap_errs); end
      bad = 0;
      for (int i = 0; i < 64; i++) if (got[i] !== 32'(1000 + i)) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL gaps_data got %0d bad words expected 0", bad); end
   endtask

   task automatic test_backpressure();
      int ok, bad;
      run_pass(0, 1, 127, 0, 0, ok);
      checks++; if (ok !== 1) begin failures++; $display("FAIL bp_complete got %0d expected 1", ok); end
      bad = 0;
      for (int i = 0; i < 64; i++) if (got[i] !== 32'(1000 + i)) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL bp_order got %0d bad words expected 0", bad); end
      checks++; if (stall_errs !== 0) begin failures++; $display("FAIL bp_stall_hold got %0d unstable cycles expected 0", stall_errs); end
      checks++; if (last_cnt !== 1 || last_idx !== 63) begin failures++; $display("FAIL bp_tlast got count=%0d idx=%0d expected 1 63", last_cnt, last_idx); end
   endtask

   task automatic test_done_overlap();
      int ok, bad;
      run_pass(0, 0, 127, 1, 0, ok);
      checks++; if (ok !== 1) begin failures++; $display("FAIL overlap_complete got %0d expected 1", ok); end
      checks++; if (start_cyc - kick_cyc !== 3) begin failures++; $display("FAIL overlap_start_delay got %0d expected 3", start_cyc - kick_cyc); end
      checks++; if (start_pulses !== 1) begin failures++; $display("FAIL overlap_start_pulses got %0d expected 1", start_pulses); end
      bad = 0;
      for (int i = 0; i < 64; i++) if (got[i] !== 32'(1000 + i)) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL overlap_data got %0d bad words expected 0", bad); end
   endtask

   task automatic test_framing();
      int ok, exp_rise;
      logic exp_err;
`ifdef MM_TLAST_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      run_pass(0, 0, 99, 0, 0, ok);
      exp_rise = exp_err ? tlast_cyc + 1 : -1;
      checks++; if (ok !== 1) begin failures++; $display("FAIL framing_complete got %0d expected 1", ok); end
      checks++; if (err_rise !== exp_rise) begin failures++; $display("FAIL framing_err_rise got %0d expected %0d", err_rise, exp_rise); end
      checks++; if (bus.err !== exp_err) begin failures++; $display("FAIL framing_err_sticky got %b expected %b", bus.err, exp_err); end
   endtask

   task automatic test_midrun_reset();
      int ok, bad;
      run_pass(0, 0, 127, 0, 10, ok);
      checks++; if (ok !== 1 || got_n !== 10) begin failures++; $display("FAIL midreset_reach got ok=%0d beats=%0d expected 1 10", ok, got_n); end
      checks++;
      if ({bus.s_tready, bus.m_tvalid, bus.m_tlast, bus.bram_we, bus.bram_sel, bus.mm_start, bus.err} !== 7'b0000100) begin
         failures++;
         $display("FAIL midreset_ctrl got %b expected 0000100", {bus.s_tready, bus.m_tvalid, bus.m_tlast, bus.bram_we, bus.bram_sel, bus.mm_start, bus.err});
      end
      checks++;
      if (bus.m_tdata !== 32'd0 || bus.bram_addr !== 7'd0 || bus.bram_wrdata !== 32'd0) begin
         failures++;
         $display("FAIL midreset_data got tdata=%h addr=%h wrdata=%h expected all zero", bus.m_tdata, bus.bram_addr, bus.bram_wrdata);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (bus.s_tready !== 1'b1) begin failures++; $display("FAIL midreset_ready got %b expected 1", bus.s_tready); end
      run_pass(0, 0, 127, 0, 0, ok);
      checks++; if (ok !== 1 || fill_errs !== 0) begin failures++; $display("FAIL midreset_rerun got ok=%0d fill_errs=%0d expected 1 0", ok, fill_errs); end
      bad = 0;
      for (int i = 0; i < 64; i++) if (got[i] !== 32'(1000 + i)) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL midreset_data_rerun got %0d bad words expected 0", bad); end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
      idle_inputs();
      test_reset();
      test_basic();
      test_input_gaps();
      test_backpressure();
      test_done_overlap();
      test_framing();
      test_midrun_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
